xs3_serial_converter: RTL

Serial BCD-to-excess-3 converter stepped by the divided slow clock. Samples one input bit per slow-clock rising edge, LSB first, and runs the classic 7-state Mealy converter to emit the excess-3 bit on the same step. Assembles each 4-bit digit for LED display. Sits directly downstream of the clock divider and runs entirely in the `clk100Mhz` domain, using `slowClk` as a step enable and never as a clock.

---
 rtl/xs3_serial_converter.sv | 64 ++++++
 1 files changed

// File: rtl/xs3_serial_converter.sv
// xs3_serial_converter: serial LSB-first BCD to excess-3 Mealy converter stepped by slowClk edges.
module xs3_serial_converter #(
  parameter bit STEP_ON_RISE = 1'b1
) (
  input  logic       clk100Mhz,
  input  logic       resetn,
  input  logic       slowClk,
  input  logic       bitIn,
  output logic       zOut,
  output logic [1:0] bitCount,
  output logic [3:0] bcdDigit,
  output logic [3:0] xs3Digit,
  output logic       digitValid,
  output logic       invalid
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6} state_t;
  state_t     state_q, state_d;
  logic       slow_prev_q;
  logic [3:0] in_sr_q, in_sr_d, out_sr_q, out_sr_d;
  logic       step, z_d, done;
  assign step = STEP_ON_RISE ? (slowClk & ~slow_prev_q) : (~slowClk & slow_prev_q);
  assign done = (state_q == S5) || (state_q == S6);
  // States where addend^carry is 1 invert the input bit
  assign z_d = bitIn ^ ((state_q == S0) || (state_q == S1) || (state_q == S4) || (state_q == S6));
  always_comb begin
    state_d = (state_q == S0) ? (bitIn ? S2 : S1) :
              (state_q == S1) ? (bitIn ? S4 : S3) :
              (state_q == S2) ? S4 :
              (state_q == S3) ? S5 :
              (state_q == S4) ? (bitIn ? S6 : S5) : S0;
    in_sr_d = in_sr_q;
    in_sr_d[bitCount] = bitIn;
    out_sr_d = out_sr_q;
    out_sr_d[bitCount] = z_d;
  end
  always_ff @(posedge clk100Mhz) begin
    slow_prev_q <= slowClk;
    if (!resetn) begin
      state_q    <= S0;
      zOut       <= 1'b0;
      bitCount   <= 2'd0;
      bcdDigit   <= 4'd0;
      xs3Digit   <= 4'd0;
      digitValid <= 1'b0;
      invalid    <= 1'b0;
      in_sr_q    <= 4'd0;
      out_sr_q   <= 4'd0;
    end else begin
      digitValid <= step && done;
      if (step) begin
        state_q  <= state_d;
        zOut     <= z_d;
        bitCount <= bitCount + 2'd1;
        in_sr_q  <= in_sr_d;
        out_sr_q <= out_sr_d;
        if (done) begin
          bcdDigit <= in_sr_d;
          xs3Digit <= out_sr_d;
          invalid  <= in_sr_d > 4'd9;
        end
      end
    end
  end
endmodule
